// File: rtl/init_seq_ctrl.sv
// Power-up sequencer: startup delay, ordered device-init handshakes with minimum wait,
// timeout and retry, then on-demand register reads with timeout and status export.
module init_seq_ctrl #(
    parameter int N_DEV         = 2,
    parameter int CNT_W         = 32,
    parameter int STARTUP_DELAY = 500000,
    parameter int MIN_WAIT      = 500000,
    parameter int STEP_TIMEOUT  = 1000000,
    parameter int MAX_RETRY     = 2,
    parameter int RD_TIMEOUT    = 600
) (
    input  logic             clk_1us,
    input  logic             reset,
    output logic [N_DEV-1:0] dev_start,
    input  logic [N_DEV-1:0] dev_done,
    input  logic             rd_req_n,
    output logic             rd_start,
    input  logic             rd_done,
    output logic             all_done,
    output logic             fail,
    output logic [3:0]       fail_idx,
    output logic             rd_err,
    output logic [3:0]       retry_cnt,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_STARTUP  = 4'd1,
        S_START    = 4'd2,
        S_WAIT     = 4'd3,
        S_NEXT     = 4'd4,
        S_READY    = 4'd5,
        S_RD_START = 4'd6,
        S_RD_WAIT  = 4'd7,
        S_FAIL     = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_DELAY - 1);
    localparam logic [CNT_W-1:0] MIN_LAST     = CNT_W'(MIN_WAIT - 1);
    localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(STEP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RD_LAST      = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [3:0]       LAST_IDX     = 4'(N_DEV - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

    state_t           cur_state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       idx;
    logic [3:0]       next_idx;
    logic [3:0]       next_retry;
    logic             next_rd_err;
    logic             seen;

    logic [N_DEV-1:0] dev_s1, dev_s2, dev_s3;
    logic             rd_s1, rd_s2, rd_s3;
    logic             req_s1, req_s2;
    logic [15:0]      dev_rise;
    logic             dev_hit;
    logic             rd_hit;

    logic [N_DEV-1:0] dev_start_d;
    logic             rd_start_d;
    logic             all_done_d;
    logic             fail_d;
    logic [3:0]       fail_idx_d;

    // Two-flop synchronizers plus one history flop for rising-edge detection.
    always_ff @(posedge clk_1us) begin
        if (!reset) begin
            dev_s1 <= '0;
            dev_s2 <= '0;
            dev_s3 <= '0;
            rd_s1  <= 1'b0;
            rd_s2  <= 1'b0;
            rd_s3  <= 1'b0;
            req_s1 <= 1'b1;
            req_s2 <= 1'b1;
        end else begin
            dev_s1 <= dev_done;
            dev_s2 <= dev_s1;
            dev_s3 <= dev_s2;
            rd_s1  <= rd_done;
            rd_s2  <= rd_s1;
            rd_s3  <= rd_s2;
            req_s1 <= rd_req_n;
            req_s2 <= req_s1;
        end
    end

    assign dev_rise = 16'(dev_s2 & ~dev_s3);
    assign dev_hit  = dev_rise[idx];
    assign rd_hit   = rd_s2 & ~rd_s3;

    // NOTE: synchronous reset inside the clocked block; all state uses non-blocking
    // assignments so every register samples pre-edge values.
    always_ff @(posedge clk_1us) begin
        if (!reset) begin
            cur_state <= S_STARTUP;
            cnt       <= '0;
            idx       <= '0;
            retry_cnt <= '0;
            seen      <= 1'b0;
            rd_err    <= 1'b0;
            dev_start <= '0;
            rd_start  <= 1'b0;
            all_done  <= 1'b0;
            fail      <= 1'b0;
            fail_idx  <= '0;
        end else begin
            cur_state <= next_state;
            idx       <= next_idx;
            retry_cnt <= next_retry;
            rd_err    <= next_rd_err;
            if (next_state != cur_state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
            // Sticky completion catches done edges that arrive before MIN_WAIT elapses.
            if (cur_state == S_START || cur_state == S_RD_START) begin
                seen <= 1'b0;
            end else if ((cur_state == S_WAIT && dev_hit) || (cur_state == S_RD_WAIT && rd_hit)) begin
                seen <= 1'b1;
            end
            dev_start <= dev_start_d;
            rd_start  <= rd_start_d;
            all_done  <= all_done_d;
            fail      <= fail_d;
            fail_idx  <= fail_idx_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state  = cur_state;
        next_idx    = idx;
        next_retry  = retry_cnt;
        next_rd_err = rd_err;
        case (cur_state)
            S_STARTUP: begin
                if (cnt == STARTUP_LAST) begin
                    next_state = S_START;
                    next_idx   = '0;
                end
            end
            S_START:   next_state = S_WAIT;
            S_WAIT: begin
                if ((seen || dev_hit) && cnt >= MIN_LAST) begin
                    next_state = S_NEXT;
                end else if (cnt == STEP_LAST && retry_cnt < RETRY_MAX) begin
                    next_retry = retry_cnt + 4'd1;
                    next_state = S_START;
                end else if (cnt == STEP_LAST) begin
                    next_state = S_FAIL;
                end
            end
            S_NEXT: begin
                if (idx == LAST_IDX) begin
                    next_state = S_READY;
                end else begin
                    next_idx   = idx + 4'd1;
                    next_retry = '0;
                    next_state = S_START;
                end
            end
            S_READY: begin
                if (!req_s2) next_state = S_RD_START;
            end
            S_RD_START: next_state = S_RD_WAIT;
            S_RD_WAIT: begin
                if (seen || rd_hit) begin
                    next_rd_err = 1'b0;
                    next_state  = S_READY;
                end else if (cnt == RD_LAST) begin
                    next_rd_err = 1'b1;
                    next_state  = S_READY;
                end
            end
            S_FAIL:    next_state = S_FAIL;
            default:   next_state = S_STARTUP;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state.
    always_comb begin
        dev_start_d = '0;
        for (int i = 0; i < N_DEV; i++) begin
            dev_start_d[i] = (next_state == S_START) && (next_idx == 4'(i));
        end
        rd_start_d = (next_state == S_RD_START);
        all_done_d = (next_state == S_READY) || (next_state == S_RD_START) ||
                     (next_state == S_RD_WAIT);
        fail_d     = (next_state == S_FAIL);
        fail_idx_d = (next_state == S_FAIL) ? next_idx : 4'd0;
    end

    assign state = cur_state;

endmodule
